fifo_uart_tx: RTL and testbench

Serial transmitter that drains the 8-bit FIFO and shifts each byte out as a UART frame. It sits directly downstream of the FIFO. It watches `empt`, issues single-cycle `rd_en` pulses, captures `data_out` and serialises it: start bit, 8 data bits LSB first, optional even parity, one stop bit. It issues a FIFO read only when it is idle and the FIFO is non-empty, so it never over-reads.

---
 rtl/fifo_uart_tx.sv | 132 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains an upstream 8-bit FIFO one byte at a time.
// Frame: start bit, 8 data bits LSB first, optional even parity, one stop bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empt,
  input  logic [7:0] fifo_data,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_reg, parity_next;
  logic          tx_reg, tx_next;
  logic          rd_en_reg, rd_en_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          bit_end;

  assign bit_end = (cnt_reg == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      tx_reg      <= 1'b1;
      rd_en_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      tx_reg      <= tx_next;
      rd_en_reg   <= rd_en_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    done_next    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empt) state_next = FETCH;
      end
      FETCH: begin
        state_next = LOAD;
      end
      LOAD: begin
        shift_next   = fifo_data;
        parity_next  = 1'b0;
        bit_idx_next = '0;
        state_next   = START;
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_next   = {1'b0, shift_reg[7:1]};
          parity_next  = parity_reg ^ shift_reg[0];
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) state_next = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // The baud counter restarts on every state change and wraps at each bit boundary.
    if (state_next != state_reg || bit_end) cnt_next = '0;
    else                                    cnt_next = cnt_reg + CW'(1);

    // Outputs are derived from the upcoming state so they leave the flops aligned with it.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = parity_next;
      default: tx_next = 1'b1;
    endcase
    rd_en_next = (state_next == FETCH);
    busy_next  = (state_next != IDLE);
  end

  assign fifo_rd_en = rd_en_reg;
  assign tx         = tx_reg;
  assign busy       = busy_reg;
  assign tx_done    = done_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (without and with parity) share one FIFO byte stream;
// a scoreboard of expected frames is filled at push time and drained by a line monitor.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] fifo_empt, fifo_rd_en, tx, busy, tx_done;
  logic [7:0] fifo_data [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] src_mem [256];
  int         src_wr = 0;
  int         rd_ptr [2] = '{0, 0};
  int         overread [2] = '{0, 0};

  logic [10:0] exp_frame [2][64];
  logic [7:0]  exp_byte [2][64];
  int          exp_wr [2] = '{0, 0};
  int          exp_rd [2] = '{0, 0};

  int          rd_cnt [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          nstart [2] = '{0, 0};
  int          start_cyc [2][64];
  bit          in_frame [2] = '{0, 0};
  int          mcyc [2];
  logic [10:0] got [2];
  logic [10:0] want [2];
  bit          glitch [2];
  logic [7:0]  cur_byte [2];

  initial forever #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    assign fifo_empt[gi] = (rd_ptr[gi] == src_wr);
    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(gi == 1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .fifo_empt (fifo_empt[gi]),
      .fifo_data (fifo_data[gi]),
      .fifo_rd_en(fifo_rd_en[gi]),
      .tx        (tx[gi]),
      .busy      (busy[gi]),
      .tx_done   (tx_done[gi])
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: data valid after the edge that samples rd_en, garbage otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (fifo_rd_en[i] === 1'b1) begin
        if (rd_ptr[i] == src_wr) overread[i] <= overread[i] + 1;
        else begin
          fifo_data[i] <= src_mem[rd_ptr[i]];
          rd_ptr[i]    <= rd_ptr[i] + 1;
        end
      end else begin
        fifo_data[i] <= 8'($urandom);
      end
    end
  end

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, i, act, req);
    end
  endtask

  // Expected line bits, slot 0 first: start, data LSB first, [parity], stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b, input int p);
    logic [10:0] f;
    int ones;
    f    = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      f[k+1] = b[k];
      ones += int'(b[k]);
    end
    if (p != 0) f[9] = (ones % 2 == 1);
    return f;
  endfunction

  function automatic int flen(input int p);
    return (10 + p) * CPB;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    src_mem[src_wr] = b;
    for (int i = 0; i < 2; i++) begin
      exp_frame[i][exp_wr[i]] = make_frame(b, i);
      exp_byte[i][exp_wr[i]]  = b;
      exp_wr[i]++;
    end
    src_wr++;
  endtask

  // Line monitor: one frame per falling start edge, sampled on the falling clock edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (fifo_rd_en[i] === 1'b1) rd_cnt[i]++;
        if (tx_done[i] === 1'b1) done_cnt[i]++;
        if (rst !== 1'b1) begin
          in_frame[i] = 1'b0;
        end else begin
          if (!in_frame[i] && tx[i] === 1'b0) begin
            in_frame[i] = 1'b1;
            mcyc[i]     = 0;
            glitch[i]   = 1'b0;
            got[i]      = '1;
            start_cyc[i][nstart[i]] = cyc;
            nstart[i]++;
            check("frame_expected", i, (exp_rd[i] < exp_wr[i]) ? 1 : 0, 1);
            if (exp_rd[i] < exp_wr[i]) begin
              want[i]     = exp_frame[i][exp_rd[i]];
              cur_byte[i] = exp_byte[i][exp_rd[i]];
              exp_rd[i]++;
            end else begin
              want[i]     = '0;
              cur_byte[i] = '0;
            end
          end
          if (in_frame[i]) begin
            if (mcyc[i] < flen(i)) begin
              if (mcyc[i] % CPB == 0) got[i][mcyc[i] / CPB] = tx[i];
              else if (tx[i] !== got[i][mcyc[i] / CPB]) glitch[i] = 1'b1;
              if (busy[i] !== 1'b1 || tx_done[i] !== 1'b0 || fifo_rd_en[i] !== 1'b0) glitch[i] = 1'b1;
              mcyc[i]++;
            end else begin
              check("frame_bits", i, 32'(got[i]), 32'(want[i]));
              check("frame_timing", i, 32'(glitch[i]), 0);
              check("tx_done_pulse", i, 32'(tx_done[i]), 1);
              check("busy_after_stop", i, 32'(busy[i]), 0);
              $display("rx dut%0d byte %02h frame %03h at cycle %0d", i, cur_byte[i], got[i], cyc);
              in_frame[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    int rd0 [2];
    int dn0 [2];
    int ns0 [2];
    int low [2];
    int bad [2];
    int n;

    // Reset held for two edges with a byte already waiting.
    rst = 1'b0;
    push_byte(8'h04);
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("reset_tx", i, 32'(tx[i]), 1);
        check("reset_rd_en", i, 32'(fifo_rd_en[i]), 0);
        check("reset_busy", i, 32'(busy[i]), 0);
        check("reset_tx_done", i, 32'(tx_done[i]), 0);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("first_rd_en", i, 32'(fifo_rd_en[i]), 1);
      check("first_busy", i, 32'(busy[i]), 1);
    end
    repeat (60) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("single_rd_count", i, rd_cnt[i], 1);
      check("single_done_count", i, done_cnt[i], 1);
    end

    // Back-to-back: three bytes queued at once.
    for (int i = 0; i < 2; i++) begin
      rd0[i] = rd_cnt[i];
      dn0[i] = done_cnt[i];
      ns0[i] = nstart[i];
      low[i] = 0;
    end
    push_byte(8'h04);
    push_byte(8'h05);
    push_byte(8'h06);
    repeat (160) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (busy[i] === 1'b0) low[i]++;
    end
    for (int i = 0; i < 2; i++) begin
      check("b2b_rd_count", i, rd_cnt[i] - rd0[i], 3);
      check("b2b_done_count", i, done_cnt[i] - dn0[i], 3);
      check("b2b_period_1", i, start_cyc[i][ns0[i]+1] - start_cyc[i][ns0[i]], flen(i) + 3);
      check("b2b_period_2", i, start_cyc[i][ns0[i]+2] - start_cyc[i][ns0[i]+1], flen(i) + 3);
      check("b2b_busy_low", i, low[i], 2 + 160 - 3 * (flen(i) + 3) + 1);
    end

    // Parity pair followed by random bytes with random gaps.
    for (int i = 0; i < 2; i++) rd0[i] = rd_cnt[i];
    push_byte(8'h05);
    push_byte(8'h07);
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, 60)) @(negedge clk);
      push_byte(8'($urandom));
    end
    repeat (900) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("all_frames_seen", i, exp_rd[i], exp_wr[i]);
      check("random_rd_count", i, rd_cnt[i] - rd0[i], 18);
    end

    // Reset during data bit 3 of 0x06; the byte is lost and 0x07 follows.
    for (int i = 0; i < 2; i++) begin
      rd0[i] = rd_cnt[i];
      dn0[i] = done_cnt[i];
    end
    push_byte(8'h06);
    n = 0;
    while (tx[0] !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_start_seen", 0, (n < 20) ? 1 : 0, 1);
    repeat (4 * CPB + 1) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("midreset_tx", i, 32'(tx[i]), 1);
      check("midreset_busy", i, 32'(busy[i]), 0);
      check("midreset_tx_done", i, 32'(tx_done[i]), 0);
    end
    push_byte(8'h07);
    @(negedge clk);
    rst = 1'b1;
    repeat (60) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("midreset_rd_count", i, rd_cnt[i] - rd0[i], 2);
      check("midreset_done_count", i, done_cnt[i] - dn0[i], 1);
      check("midreset_drained", i, exp_rd[i], exp_wr[i]);
    end

    // Empty FIFO: the transmitter must stay idle.
    for (int i = 0; i < 2; i++) bad[i] = 0;
    repeat (100) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (fifo_rd_en[i] !== 1'b0 || tx[i] !== 1'b1 || busy[i] !== 1'b0) bad[i]++;
    end
    for (int i = 0; i < 2; i++) begin
      check("empty_idle_cycles", i, bad[i], 0);
      check("no_overread", i, overread[i], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
